// File: rtl/accel_spi_reader.sv
// SPI mode-3 poller for an ADXL345-class accelerometer: two init writes after a
// power-up wait, then a 5-byte DATAX0..DATAY1 burst every poll period.
//
// state   | meaning
// STARTUP | sensor power-up wait
// WR_FMT  | write DATA_FORMAT (0x31 <- 0x00)
// GAP1    | cs_n high between the two init writes
// WR_PWR  | write POWER_CTL (0x2D <- 0x08)
// GAP2    | cs_n high after init
// IDLE    | wait for poll counter to reach 0
// READ    | 5-byte multi-byte read from 0x32
// UPDATE  | convert captured data, pulse o_valid
module accel_spi_reader #(
  parameter int CLK_DIV        = 25,
  parameter int POLL_PERIOD    = 50000,
  parameter int STARTUP_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       arst_n,
  output logic       o_spi_cs_n,
  output logic       o_spi_sclk,
  output logic       o_spi_mosi,
  input  logic       i_spi_miso,
  output logic [7:0] o_accel_x,
  output logic [7:0] o_accel_y,
  output logic       o_valid,
  output logic       o_init_done
);

  localparam int SU_W = $clog2(STARTUP_CYCLES + 1);
  localparam int PO_W = $clog2(POLL_PERIOD + 1);
  localparam int DV_W = $clog2(2 * CLK_DIV + 1);

  localparam logic [DV_W-1:0] HALF_LOAD = DV_W'(CLK_DIV - 1);
  localparam logic [DV_W-1:0] GAP_LOAD  = DV_W'(2 * CLK_DIV - 1);
  localparam logic [SU_W-1:0] SU_LAST   = SU_W'(STARTUP_CYCLES - 1);
  localparam logic [PO_W-1:0] POLL_LOAD = PO_W'(POLL_PERIOD - 1);

  // half-period index of the hold phase: setup is half 0, bits are 1..16N
  localparam logic [6:0] WR_LAST = 7'd33;
  localparam logic [6:0] RD_LAST = 7'd81;

  localparam logic [39:0] TX_FMT = 40'h31_00_00_00_00;
  localparam logic [39:0] TX_PWR = 40'h2D_08_00_00_00;
  localparam logic [39:0] TX_RD  = 40'hF2_00_00_00_00;

  typedef enum logic [2:0] {
    STARTUP, WR_FMT, GAP1, WR_PWR, GAP2, IDLE, READ, UPDATE
  } state_t;

  state_t          state;
  logic [SU_W-1:0] su_cnt;
  logic [PO_W-1:0] poll_cnt;
  logic [DV_W-1:0] div_cnt;
  logic [6:0]      half_cnt;
  logic [39:0]     tx_sr;
  logic [31:0]     rx_sr;

  logic [6:0] last_half;
  logic [6:0] nxt_half;

  assign last_half = (state == READ) ? RD_LAST : WR_LAST;
  assign nxt_half  = half_cnt + 7'd1;

  function automatic logic [7:0] sat8(input logic [7:0] d1, input logic [7:0] d0);
    logic signed [15:0] raw;
    raw = signed'({d1, d0});
    if (raw > 16'sd511)
      return 8'h7F;
    else if (raw < -16'sd512)
      return 8'h80;
    else
      return raw[9:2];
  endfunction

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= STARTUP;
      su_cnt      <= '0;
      poll_cnt    <= '0;
      div_cnt     <= '0;
      half_cnt    <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      o_spi_cs_n  <= 1'b1;
      o_spi_sclk  <= 1'b1;
      o_spi_mosi  <= 1'b0;
      o_accel_x   <= '0;
      o_accel_y   <= '0;
      o_valid     <= 1'b0;
      o_init_done <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (poll_cnt != '0)
        poll_cnt <= poll_cnt - 1'b1;

      case (state)
        STARTUP: begin
          if (su_cnt == SU_LAST) begin
            state      <= WR_FMT;
            o_spi_cs_n <= 1'b0;
            o_spi_sclk <= 1'b1;
            o_spi_mosi <= TX_FMT[39];
            tx_sr      <= {TX_FMT[38:0], 1'b0};
            half_cnt   <= '0;
            div_cnt    <= HALF_LOAD;
          end else begin
            su_cnt <= su_cnt + 1'b1;
          end
        end

        WR_FMT, WR_PWR, READ: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
          end else if (half_cnt == last_half) begin
            o_spi_cs_n <= 1'b1;
            o_spi_mosi <= 1'b0;
            div_cnt    <= GAP_LOAD;
            case (state)
              WR_FMT: state <= GAP1;
              WR_PWR: begin
                state       <= GAP2;
                o_init_done <= 1'b1;
              end
              default: state <= UPDATE;
            endcase
          end else begin
            div_cnt  <= HALF_LOAD;
            half_cnt <= nxt_half;
            if (nxt_half == last_half) begin
              o_spi_sclk <= 1'b1;
            end else if (nxt_half[0]) begin
              // falling edge; the first bit was already presented with cs_n
              o_spi_sclk <= 1'b0;
              if (nxt_half != 7'd1) begin
                o_spi_mosi <= tx_sr[39];
                tx_sr      <= {tx_sr[38:0], 1'b0};
              end
            end else begin
              o_spi_sclk <= 1'b1;
              rx_sr      <= {rx_sr[30:0], i_spi_miso};
            end
          end
        end

        GAP1: begin
          if (div_cnt == '0) begin
            state      <= WR_PWR;
            o_spi_cs_n <= 1'b0;
            o_spi_sclk <= 1'b1;
            o_spi_mosi <= TX_PWR[39];
            tx_sr      <= {TX_PWR[38:0], 1'b0};
            half_cnt   <= '0;
            div_cnt    <= HALF_LOAD;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end

        GAP2: begin
          if (div_cnt == '0)
            state <= IDLE;
          else
            div_cnt <= div_cnt - 1'b1;
        end

        IDLE: begin
          if (poll_cnt == '0) begin
            state      <= READ;
            poll_cnt   <= POLL_LOAD;
            o_spi_cs_n <= 1'b0;
            o_spi_sclk <= 1'b1;
            o_spi_mosi <= TX_RD[39];
            tx_sr      <= {TX_RD[38:0], 1'b0};
            half_cnt   <= '0;
            div_cnt    <= HALF_LOAD;
          end
        end

        UPDATE: begin
          // rx_sr holds X0, X1, Y0, Y1 from MSB down; the command byte shifted out
          o_accel_x <= sat8(rx_sr[23:16], rx_sr[31:24]);
          o_accel_y <= sat8(rx_sr[7:0], rx_sr[15:8]);
          o_valid   <= 1'b1;
          state     <= IDLE;
        end

        default: state <= STARTUP;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_spi_reader.sv
// Bench for accel_spi_reader: SPI slave model, transaction monitor and a
// scoreboard of expected X/Y samples pushed whenever a read response is served.
module tb_accel_spi_reader;

  localparam int CD = 2;
  localparam int PP = 400;
  localparam int SU = 10;

  logic       clk    = 1'b0;
  logic       arst_n = 1'b0;
  logic       cs_n, sclk, mosi;
  logic       miso   = 1'b0;
  logic [7:0] ax, ay;
  logic       valid, init_done;

  accel_spi_reader #(
    .CLK_DIV(CD), .POLL_PERIOD(PP), .STARTUP_CYCLES(SU)
  ) dut (
    .clk(clk),
    .arst_n(arst_n),
    .o_spi_cs_n(cs_n),
    .o_spi_sclk(sclk),
    .o_spi_mosi(mosi),
    .i_spi_miso(miso),
    .o_accel_x(ax),
    .o_accel_y(ay),
    .o_valid(valid),
    .o_init_done(init_done)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // reference conversion: saturate to the 10-bit range, then floor-divide by 4
  function automatic logic [7:0] model(input logic [7:0] d0, input logic [7:0] d1);
    int v;
    v = int'(signed'({d1, d0}));
    if (v > 511) return 8'h7F;
    if (v < -512) return 8'h80;
    return 8'(v >>> 2);
  endfunction

  logic [31:0] resp_q[$];   // {X0, X1, Y0, Y1}
  logic [15:0] exp_q[$];    // {x, y}
  logic [39:0] s_tx, s_rx;

  // slave: a read is any transaction that starts once init is done
  always @(negedge cs_n) begin
    logic [31:0] r;
    s_rx = '0;
    if (init_done) begin
      r = (resp_q.size() != 0) ? resp_q.pop_front() : $urandom;
      s_tx = {8'h00, r};
      exp_q.push_back({model(r[31:24], r[23:16]), model(r[15:8], r[7:0])});
    end else begin
      s_tx = '0;
    end
  end

  always @(negedge sclk) begin
    if (!cs_n) begin
      miso = s_tx[39];
      s_tx = {s_tx[38:0], 1'b0};
    end
  end

  always @(posedge sclk) begin
    if (!cs_n) s_rx = {s_rx[38:0], mosi};
  end

  int cyc = 0, low_cnt = 0, rise_cnt = 0, wr_idx = 0, last_rise = 0, last_rd_fall = 0;
  int valids_since = 0, valid_cnt = 0, idle_err = 0, mosi_err = 0;
  bit in_xfer = 0, is_rd = 0, seen_rd = 0, cs_prev = 1, sclk_prev = 1, mosi_prev = 0;

  always @(negedge clk) begin
    int nb;
    logic [15:0] e;
    cyc++;
    if (!arst_n) begin
      in_xfer      = 0;
      wr_idx       = 0;
      seen_rd      = 0;
      cs_prev      = 1;
      sclk_prev    = 1;
      last_rise    = cyc;
      valids_since = 0;
    end else begin
      if (cs_n && !sclk) idle_err++;
      if (valid) begin
        valid_cnt++;
        valids_since++;
        chk("valid_latency", 64'(cyc - last_rise), 64'd1);
        if (exp_q.size() == 0) begin
          chk("valid_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("accel_x", ax, e[15:8]);
          chk("accel_y", ay, e[7:0]);
        end
      end
      if (cs_prev && !cs_n) begin
        in_xfer  = 1;
        is_rd    = init_done;
        low_cnt  = 1;
        rise_cnt = 0;
        chk("cs_high_gap_ge4", 64'((cyc - last_rise) >= 4), 64'd1);
        if (is_rd) begin
          chk("writes_before_read", 64'(wr_idx), 64'd2);
          if (seen_rd) begin
            chk("poll_gap", 64'(cyc - last_rd_fall), 64'(PP));
            chk("valid_per_read", 64'(valids_since), 64'd1);
          end
          seen_rd      = 1;
          last_rd_fall = cyc;
          valids_since = 0;
        end
      end else if (in_xfer && !cs_n) begin
        low_cnt++;
        if (!sclk_prev && sclk) rise_cnt++;
        if (sclk_prev && sclk && mosi !== mosi_prev) mosi_err++;
      end else if (in_xfer && cs_n) begin
        in_xfer   = 0;
        last_rise = cyc;
        nb        = is_rd ? 5 : 2;
        chk("cs_low_cycles", 64'(low_cnt), 64'((2 + 16 * nb) * CD));
        chk("sclk_rises", 64'(rise_cnt), 64'(8 * nb));
        if (is_rd) begin
          chk("read_mosi", s_rx, 64'h00F200000000);
        end else begin
          chk("write_mosi", s_rx, (wr_idx == 0) ? 64'h3100 : 64'h2D08);
          chk("init_done_at_end", init_done, 64'(wr_idx == 1));
          wr_idx++;
        end
      end
      cs_prev   = cs_n;
      sclk_prev = sclk;
      mosi_prev = mosi;
    end
  end

  initial begin
    int n;
    int vc;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 1);
    chk("rst_mosi", mosi, 0);
    chk("rst_x", ax, 0);
    chk("rst_y", ay, 0);
    chk("rst_valid", valid, 0);
    chk("rst_init_done", init_done, 0);

    resp_q.push_back(32'h80_01_00_FF);  // 384 -> 0x60, -256 -> 0xC0
    resp_q.push_back(32'h00_04_00_F0);  // 0x0400 -> 7F, 0xF000 -> 80
    resp_q.push_back(32'hFF_01_00_FE);  // 0x01FF -> 7F, 0xFE00 -> 80
    resp_q.push_back(32'hFF_FF_00_02);  // 0xFFFF -> FF, 0x0200 -> 7F
    resp_q.push_back(32'hFF_FD_03_00);  // 0xFDFF -> 80, 0x0003 -> 00
    resp_q.push_back(32'hFC_FF_FC_01);  // 0xFFFC -> FF, 0x01FC -> 7F

    @(posedge clk);
    #1 arst_n = 1'b1;
    n = 0;
    while (cs_n && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    chk("first_cs_fall", 64'(n), 64'(SU));

    n = 0;
    while (valid_cnt < 7 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("valid_count", 64'(valid_cnt), 64'd7);

    // abort a read after its 20th rising sclk edge
    n = 0;
    while (!(in_xfer && is_rd && rise_cnt == 20) && n < 1000) begin
      @(negedge clk);
      #1 n++;
    end
    chk("bit20_reached", 64'(rise_cnt), 64'd20);
    arst_n = 1'b0;
    #1;
    chk("abort_cs_n", cs_n, 1);
    chk("abort_sclk", sclk, 1);
    chk("abort_x", ax, 0);
    chk("abort_y", ay, 0);
    exp_q.delete();
    vc = valid_cnt;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 arst_n = 1'b1;

    n = 0;
    while (!init_done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("reinit_done", init_done, 1);
    chk("no_valid_after_abort", 64'(valid_cnt), 64'(vc));

    n = 0;
    while (valid_cnt < vc + 2 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("valid_count_after_reinit", 64'(valid_cnt), 64'(vc + 2));
    chk("mosi_stable_sclk_high", 64'(mosi_err), 64'd0);
    chk("sclk_idle_high", 64'(idle_err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
